// File: rtl/fetch_branch_unit_if.sv
// Controller strobes, ALU/register-file inputs, memory bus and debug/decode
// outputs of the fetch/branch unit, bundled as one interface.
interface fetch_branch_unit_if;
    logic        IRWrite;
    logic        PCWrite;
    logic        PCSrc;
    logic        Branch;
    logic [1:0]  BranchType;
    logic        IoD;
    logic        MemR;
    logic        MemW;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        alu_neg;
    logic [15:0] b_data;
    logic [15:0] mem_rdata;

    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] pc_q;
    logic [15:0] ir_q;
    logic [15:0] alu_out_q;
    logic [15:0] mdr_q;
    logic [6:0]  ctrl_field;
    logic [2:0]  rd_addr;
    logic [2:0]  rs1_addr;
    logic [2:0]  rs2_addr;
    logic [15:0] imm6_sext;
    logic [15:0] imm9_sext;
    logic        branch_taken;
    logic [15:0] retired_cnt;
    logic [15:0] cycle_cnt;
    logic        misalign;

    // Unit side: consumes strobes and operands, produces bus and decode.
    modport slave (
        input  IRWrite, PCWrite, PCSrc, Branch, BranchType, IoD, MemR, MemW,
        input  alu_result, alu_zero, alu_neg, b_data, mem_rdata,
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        output pc_q, ir_q, alu_out_q, mdr_q, ctrl_field,
        output rd_addr, rs1_addr, rs2_addr, imm6_sext, imm9_sext,
        output branch_taken, retired_cnt, cycle_cnt, misalign
    );

    // Controller/datapath side.
    modport master (
        output IRWrite, PCWrite, PCSrc, Branch, BranchType, IoD, MemR, MemW,
        output alu_result, alu_zero, alu_neg, b_data, mem_rdata,
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        input  pc_q, ir_q, alu_out_q, mdr_q, ctrl_field,
        input  rd_addr, rs1_addr, rs2_addr, imm6_sext, imm9_sext,
        input  branch_taken, retired_cnt, cycle_cnt, misalign
    );
endinterface

// File: rtl/fetch_branch_unit.sv
// PC / IR / ALUOut / MDR state of the 16-bit multi-cycle core, with branch
// resolution, memory address muxing, instruction decode and debug counters.
module fetch_branch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_STEP  = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    fetch_branch_unit_if.slave bus
);

    // Low address bits that must be clear for an aligned PC.
    localparam logic [15:0] ALIGN_MASK = 16'(PC_STEP - 1);

    logic [15:0] pc_r;
    logic [15:0] ir_r;
    logic [15:0] alu_out_r;
    logic [15:0] mdr_r;
    logic [15:0] retired_r;
    logic [15:0] cycle_r;
    logic        branch_taken_r;
    logic        misalign_r;

    logic        cond_s;
    logic        pc_load_s;
    logic [15:0] pc_next_s;
    logic [15:0] mem_addr_s;

    function automatic logic branch_cond(input logic [1:0] btype,
                                         input logic       zero,
                                         input logic       neg);
        logic c;
        c = 1'b0;
        case (btype)
            2'b00:   c = zero;
            2'b01:   c = ~zero;
            2'b10:   c = neg;
            2'b11:   c = ~neg;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    // Branch condition, PC write enable and PC source selection.
    always_comb begin
        cond_s    = branch_cond(bus.BranchType, bus.alu_zero, bus.alu_neg);
        pc_load_s = bus.PCWrite & (~bus.Branch | cond_s);
        if (bus.PCSrc) begin
            pc_next_s = alu_out_r;
        end else begin
            pc_next_s = bus.alu_result;
        end
    end

    // Memory address: instruction fetch from PC, data access via ALUOut.
    always_comb begin
        if (bus.IoD) begin
            mem_addr_s = alu_out_r;
        end else begin
            mem_addr_s = pc_r;
        end
    end

    // PC, sticky misalignment flag and last branch outcome.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc_r           <= RESET_PC;
            misalign_r     <= 1'b0;
            branch_taken_r <= 1'b0;
        end else begin
            if (pc_load_s) begin
                pc_r <= pc_next_s;
                if ((pc_next_s & ALIGN_MASK) != 16'h0000) begin
                    misalign_r <= 1'b1;
                end
            end
            if (bus.Branch & bus.PCWrite) begin
                branch_taken_r <= cond_s;
            end
        end
    end

    // IR with retired count, MDR and the free-running ALUOut register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ir_r      <= 16'h0000;
            retired_r <= 16'h0000;
            mdr_r     <= 16'h0000;
            alu_out_r <= 16'h0000;
        end else begin
            alu_out_r <= bus.alu_result;
            if (bus.IRWrite) begin
                ir_r      <= bus.mem_rdata;
                retired_r <= retired_r + 16'h0001;
            end
            if (bus.MemR) begin
                mdr_r <= bus.mem_rdata;
            end
        end
    end

    // Cycle counter, wraps at 16 bits.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cycle_r <= 16'h0000;
        end else begin
            cycle_r <= cycle_r + 16'h0001;
        end
    end

    assign bus.mem_addr     = mem_addr_s;
    assign bus.mem_wdata    = bus.b_data;
    assign bus.mem_rd       = bus.MemR;
    assign bus.mem_wr       = bus.MemW;
    assign bus.pc_q         = pc_r;
    assign bus.ir_q         = ir_r;
    assign bus.alu_out_q    = alu_out_r;
    assign bus.mdr_q        = mdr_r;
    assign bus.branch_taken = branch_taken_r;
    assign bus.retired_cnt  = retired_r;
    assign bus.cycle_cnt    = cycle_r;
    assign bus.misalign     = misalign_r;

    // Decode straight out of IR; stable between IR loads.
    assign bus.ctrl_field = ir_r[6:0];
    assign bus.rd_addr    = ir_r[9:7];
    assign bus.rs1_addr   = ir_r[12:10];
    assign bus.rs2_addr   = ir_r[15:13];
    assign bus.imm6_sext  = {{10{ir_r[15]}}, ir_r[15:10]};
    assign bus.imm9_sext  = {{7{ir_r[15]}}, ir_r[15:7]};

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Scoreboard bench for fetch_branch_unit: directed test-plan sequences plus
// random cycles, checked against an abstract model of the architectural state.
module tb_fetch_branch_unit;

    localparam logic [15:0] RST_PC = 16'h0010;

    logic CLK;
    logic Reset;
    fetch_branch_unit_if bus ();

    fetch_branch_unit #(.RESET_PC(RST_PC), .PC_STEP(2)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        bit irw, pcw, pcsrc, br;
        bit [1:0] btype;
        bit iod, memr, memw;
        bit [15:0] alu;
        bit zero, neg;
        bit [15:0] bdata, rdata;
    } stim_t;

    typedef struct {
        bit [15:0] pc, ir, aluout, mdr, ret, cyc;
        bit bt, mis;
        bit [15:0] maddr, wdata;
        bit rd, wr;
        bit [15:0] ctrl, rda, rs1, rs2, imm6, imm9;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Model: architectural state only.
    bit [15:0] m_pc, m_ir, m_aluout, m_mdr, m_ret, m_cyc;
    bit        m_bt, m_mis;

    int n_cmp = 0;
    int n_bad = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit [15:0] sext(input int v, input int bits);
        int x;
        x = v;
        if (x >= (1 << (bits - 1))) x = x - (1 << bits);
        return 16'(x);
    endfunction

    function automatic exp_t snapshot(input stim_t s);
        exp_t e;
        int ir;
        ir = int'(m_ir);
        e.pc = m_pc; e.ir = m_ir; e.aluout = m_aluout; e.mdr = m_mdr;
        e.ret = m_ret; e.cyc = m_cyc; e.bt = m_bt; e.mis = m_mis;
        e.maddr = s.iod ? m_aluout : m_pc;
        e.wdata = s.bdata; e.rd = s.memr; e.wr = s.memw;
        e.ctrl = 16'(ir % 128);
        e.rda  = 16'((ir / 128) % 8);
        e.rs1  = 16'((ir / 1024) % 8);
        e.rs2  = 16'(ir / 8192);
        e.imm6 = sext(ir / 1024, 6);
        e.imm9 = sext(ir / 128, 9);
        return e;
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_ir = 16'h0000; m_aluout = 16'h0000; m_mdr = 16'h0000;
        m_ret = 16'h0000; m_cyc = 16'h0000; m_bt = 1'b0; m_mis = 1'b0;
        exp_q.delete();
    endtask

    function automatic stim_t idle(input bit [15:0] alu);
        stim_t s;
        s.irw = 1'b0; s.pcw = 1'b0; s.pcsrc = 1'b0; s.br = 1'b0; s.btype = 2'b00;
        s.iod = 1'b0; s.memr = 1'b0; s.memw = 1'b0; s.alu = alu;
        s.zero = (alu == 16'h0000); s.neg = alu[15];
        s.bdata = 16'h0000; s.rdata = 16'h0000;
        return s;
    endfunction

    // One clock cycle: drive at negedge, check live combinational outputs,
    // advance the model, enqueue the post-edge expectation.
    task automatic apply(input stim_t s);
        bit taken;
        @(negedge CLK);
        bus.IRWrite = s.irw; bus.PCWrite = s.pcw; bus.PCSrc = s.pcsrc; bus.Branch = s.br;
        bus.BranchType = s.btype; bus.IoD = s.iod; bus.MemR = s.memr; bus.MemW = s.memw;
        bus.alu_result = s.alu; bus.alu_zero = s.zero; bus.alu_neg = s.neg;
        bus.b_data = s.bdata; bus.mem_rdata = s.rdata;
        #1;
        cmp("live_mem_addr", bus.mem_addr, s.iod ? m_aluout : m_pc);
        cmp("live_mem_rd", bus.mem_rd, s.memr);
        cmp("live_mem_wr", bus.mem_wr, s.memw);
        cmp("live_mem_wdata", bus.mem_wdata, s.bdata);
        case (s.btype)
            2'd0: taken = s.zero;
            2'd1: taken = !s.zero;
            2'd2: taken = s.neg;
            default: taken = !s.neg;
        endcase
        if (s.pcw && (!s.br || taken)) begin
            m_pc = s.pcsrc ? m_aluout : s.alu;
            if (m_pc % 2 == 1) m_mis = 1'b1;
        end
        if (s.pcw && s.br) m_bt = taken;
        if (s.irw) begin
            m_ir = s.rdata;
            m_ret = m_ret + 16'd1;
        end
        if (s.memr) m_mdr = s.rdata;
        m_aluout = s.alu;
        m_cyc = m_cyc + 16'd1;
        exp_q.push_back(snapshot(s));
        @(posedge CLK);
        #2;
    endtask

    // Monitor: compare every registered/decoded output after each edge.
    always @(posedge CLK) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            cmp("pc_q", bus.pc_q, mon_e.pc);
            cmp("ir_q", bus.ir_q, mon_e.ir);
            cmp("alu_out_q", bus.alu_out_q, mon_e.aluout);
            cmp("mdr_q", bus.mdr_q, mon_e.mdr);
            cmp("retired_cnt", bus.retired_cnt, mon_e.ret);
            cmp("cycle_cnt", bus.cycle_cnt, mon_e.cyc);
            cmp("branch_taken", bus.branch_taken, mon_e.bt);
            cmp("misalign", bus.misalign, mon_e.mis);
            cmp("mem_addr", bus.mem_addr, mon_e.maddr);
            cmp("mem_wdata", bus.mem_wdata, mon_e.wdata);
            cmp("mem_rd", bus.mem_rd, mon_e.rd);
            cmp("mem_wr", bus.mem_wr, mon_e.wr);
            cmp("ctrl_field", bus.ctrl_field, mon_e.ctrl);
            cmp("rd_addr", bus.rd_addr, mon_e.rda);
            cmp("rs1_addr", bus.rs1_addr, mon_e.rs1);
            cmp("rs2_addr", bus.rs2_addr, mon_e.rs2);
            cmp("imm6_sext", bus.imm6_sext, mon_e.imm6);
            cmp("imm9_sext", bus.imm9_sext, mon_e.imm9);
        end
    end

    task automatic check_reset_state(input string tag);
        cmp({tag, "_pc"}, bus.pc_q, RST_PC);
        cmp({tag, "_ir"}, bus.ir_q, 16'h0000);
        cmp({tag, "_ctrl"}, bus.ctrl_field, 7'h00);
        cmp({tag, "_aluout"}, bus.alu_out_q, 16'h0000);
        cmp({tag, "_mdr"}, bus.mdr_q, 16'h0000);
        cmp({tag, "_bt"}, bus.branch_taken, 1'b0);
        cmp({tag, "_ret"}, bus.retired_cnt, 16'h0000);
        cmp({tag, "_cyc"}, bus.cycle_cnt, 16'h0000);
        cmp({tag, "_mis"}, bus.misalign, 1'b0);
    endtask

    task automatic release_reset();
        @(posedge CLK);
        #1 Reset = 1'b0;
    endtask

    task automatic random_cycles(input int n);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s = idle(16'($urandom));
            if ($urandom_range(0, 3) == 0) s.alu = 16'h0000;
            s.zero = (s.alu == 16'h0000); s.neg = s.alu[15];
            if ($urandom_range(0, 7) == 0) begin
                s.zero = 1'($urandom); s.neg = 1'($urandom);
            end
            s.irw = ($urandom_range(0, 3) == 0);
            s.pcw = ($urandom_range(0, 2) == 0);
            s.pcsrc = 1'($urandom);
            s.br = ($urandom_range(0, 3) == 0);
            s.btype = 2'($urandom);
            s.iod = 1'($urandom);
            s.memr = 1'($urandom);
            s.memw = ($urandom_range(0, 3) == 0);
            s.bdata = 16'($urandom);
            s.rdata = 16'($urandom);
            apply(s);
        end
    endtask

    initial begin
        stim_t s;
        int budget;
        Reset = 1'b1;
        bus.IRWrite = 1'b0; bus.PCWrite = 1'b0; bus.PCSrc = 1'b0; bus.Branch = 1'b0;
        bus.BranchType = 2'b00; bus.IoD = 1'b0; bus.MemR = 1'b0; bus.MemW = 1'b0;
        bus.alu_result = 16'h0000; bus.alu_zero = 1'b1; bus.alu_neg = 1'b0;
        bus.b_data = 16'h0000; bus.mem_rdata = 16'h0000;
        model_reset();
        #12;
        check_reset_state("por");
        cmp("por_mem_addr", bus.mem_addr, RST_PC);
        release_reset();

        // Reset + fetch
        s = idle(16'h0002); s.irw = 1'b1; s.pcw = 1'b1; s.rdata = 16'h1402;
        apply(s);
        cmp("fetch_pc", bus.pc_q, 16'h0002);
        cmp("fetch_ir", bus.ir_q, 16'h1402);
        cmp("fetch_ctrl", bus.ctrl_field, 7'h02);
        cmp("fetch_ret", bus.retired_cnt, 16'h0001);

        // Decode fields
        s = idle(16'h0000); s.irw = 1'b1; s.rdata = 16'hFD81;
        apply(s);
        cmp("dec_rs2", bus.rs2_addr, 3'd7);
        cmp("dec_rs1", bus.rs1_addr, 3'd7);
        cmp("dec_rd", bus.rd_addr, 3'd3);
        cmp("dec_ctrl", bus.ctrl_field, 7'h01);
        cmp("dec_imm6", bus.imm6_sext, 16'hFFFF);
        cmp("dec_imm9", bus.imm9_sext, 16'hFFFB);

        // Taken beq
        apply(idle(16'h0040));
        s = idle(16'h0000); s.br = 1'b1; s.pcw = 1'b1; s.pcsrc = 1'b1; s.btype = 2'b00; s.zero = 1'b1;
        apply(s);
        cmp("beq_pc", bus.pc_q, 16'h0040);
        cmp("beq_taken", bus.branch_taken, 1'b1);

        // Not-taken bge
        apply(idle(16'h0080));
        s = idle(16'h8000); s.br = 1'b1; s.pcw = 1'b1; s.pcsrc = 1'b1; s.btype = 2'b11; s.neg = 1'b1;
        apply(s);
        cmp("bge_pc", bus.pc_q, 16'h0040);
        cmp("bge_taken", bus.branch_taken, 1'b0);

        // Branch without PCWrite leaves PC and branch_taken alone
        s = idle(16'h0000); s.br = 1'b1; s.pcsrc = 1'b1; s.zero = 1'b1;
        apply(s);
        cmp("brcalc_pc", bus.pc_q, 16'h0040);
        cmp("brcalc_taken", bus.branch_taken, 1'b0);

        // Load/store addressing
        apply(idle(16'h0100));
        s = idle(16'h0100); s.iod = 1'b1; s.memr = 1'b1; s.rdata = 16'hBEEF;
        apply(s);
        cmp("ld_mem_addr", bus.mem_addr, 16'h0100);
        cmp("ld_mdr", bus.mdr_q, 16'hBEEF);
        s = idle(16'h0100); s.iod = 1'b1; s.memw = 1'b1; s.memr = 1'b1; s.bdata = 16'h1234; s.rdata = 16'h5A5A;
        apply(s);
        cmp("st_wdata", bus.mem_wdata, 16'h1234);
        cmp("st_wr", bus.mem_wr, 1'b1);
        cmp("st_rd", bus.mem_rd, 1'b1);
        cmp("st_mdr", bus.mdr_q, 16'h5A5A);

        // Misaligned PC write, then asynchronous reset between edges
        s = idle(16'h0003); s.pcw = 1'b1;
        apply(s);
        cmp("mis_pc", bus.pc_q, 16'h0003);
        cmp("mis_set", bus.misalign, 1'b1);
        #1 Reset = 1'b1;
        #1;
        check_reset_state("async");
        model_reset();
        release_reset();

        // First fetch after reset comes from RESET_PC
        s = idle(RST_PC + 16'h0002); s.irw = 1'b1; s.pcw = 1'b1; s.rdata = 16'h0F3C;
        apply(s);
        cmp("refetch_pc", bus.pc_q, RST_PC + 16'h0002);

        random_cycles(400);
        #1 Reset = 1'b1;
        #1;
        check_reset_state("async2");
        model_reset();
        release_reset();
        random_cycles(150);

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge CLK);
            budget--;
        end
        #3;
        cmp("drain_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_branch_unit.md
# fetch_branch_unit

Holds the architectural PC, Instruction Register (IR), ALU-output register (ALUOut) and Memory Data Register (MDR) of the 16-bit multi-cycle core. It sits on both sides of the control FSM:
- **Upstream:** it decodes the IR into the 7-bit `ctrl_field` consumed by the controller.
- **Downstream:** it consumes the controller's `IRWrite`, `PCWrite`, `PCSrc`, `Branch`, `BranchType`, `IoD`, `MemR` and `MemW` strobes to update the PC, resolve branches and drive the memory address.

It also keeps retired-instruction and cycle counters and a sticky misalignment flag for debug.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000, PC value after reset.
- `PC_STEP`, default 2, byte increment assumed by the misalignment check; documentation only, the increment itself comes from the ALU.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `Reset`  in  1  asynchronous, active-high; forces all registers to reset values.
- `IRWrite`  in  1  latch `mem_rdata` into IR.
- `PCWrite`  in  1  PC write request.
- `PCSrc`  in  1  0: PC ← `alu_result`; 1: PC ← `alu_out_q`.
- `Branch`  in  1  qualifies `PCWrite` with the branch condition.
- `BranchType`  in  2  00 beq, 01 bne, 10 blt, 11 bge.
- `IoD`  in  1  0: `mem_addr` = PC; 1: `mem_addr` = ALUOut.
- `MemR`  in  1  read strobe; forwarded to `mem_rd`; loads MDR.
- `MemW`  in  1  write strobe; forwarded to `mem_wr`.
- `alu_result`  in  16  combinational ALU output.
- `alu_zero`  in  1  `alu_result == 0`.
- `alu_neg`  in  1  `alu_result[15]`.
- `b_data`  in  16  register-file B read data; store data.
- `mem_rdata`  in  16  memory read data; asynchronous read, valid in the same cycle as the address.
- `mem_addr`  out  16  memory address.
- `mem_wdata`  out  16  equals `b_data`.
- `mem_rd`, `mem_wr`  out  1  memory strobes.
- `pc_q`  out  16  current PC.
- `ir_q`  out  16  current instruction.
- `alu_out_q`  out  16  ALUOut register.
- `mdr_q`  out  16  MDR.
- `ctrl_field`  out  7  `ir_q[6:0]`: funct [6:3], opcode [2:0].
- `rd_addr`, `rs1_addr`, `rs2_addr`  out  3  `ir_q[9:7]`, `ir_q[12:10]`, `ir_q[15:13]`.
- `imm6_sext`  out  16  sign-extended `ir_q[15:10]`.
- `imm9_sext`  out  16  sign-extended `ir_q[15:7]`.
- `branch_taken`  out  1  registered: last branch resolution was taken.
- `retired_cnt`  out  16  number of IR loads.
- `cycle_cnt`  out  16  cycles since reset.
- `misalign`  out  1  sticky: PC was ever written with bit0 = 1.

## Operation
- **Reset values (asynchronous):**
  - `pc_q` = `RESET_PC`.
  - `ir_q` = 0, so `ctrl_field` = 0, a benign R-type add.
  - `alu_out_q`, `mdr_q` = 0.
  - `branch_taken` = 0, `retired_cnt` = 0, `cycle_cnt` = 0, `misalign` = 0.
  - Combinational outputs follow from these registers.
- **ALUOut:** loads `alu_result` every cycle, unconditionally.
- **MDR:** loads `mem_rdata` when `MemR` = 1; otherwise holds.
- **IR:** loads `mem_rdata` when `IRWrite` = 1; `retired_cnt` increments in the same cycle, wrapping FFFF→0000.
- **Branch condition `cond`:**
  - beq: `alu_zero`
  - bne: `!alu_zero`
  - blt: `alu_neg`
  - bge: `!alu_neg`
- **PC update:**
  - PC loads when `PCWrite & (!Branch | cond)`.
  - Source is `PCSrc` ? `alu_out_q` : `alu_result`.
  - `Branch` without `PCWrite` (the BRANCH target-calculation state) never writes PC.
- **`branch_taken`:** updates only in cycles with `Branch & PCWrite`, taking the value of `cond`; holds otherwise.
- **`misalign`:** sets when PC is loaded with bit0 = 1; cleared only by `Reset`.
- **Memory:**
  - `mem_addr` = `IoD` ? `alu_out_q` : `pc_q`.
  - `mem_rd` = `MemR`; `mem_wr` = `MemW`.
  - Simultaneous `MemR` & `MemW` forwards both strobes; MDR still loads.
- **Simultaneous `IRWrite` & `PCWrite` (Fetch):** IR captures `mem_rdata` addressed by the old PC; PC updates in the same edge.

## Timing
- All registers update on the rising edge of `CLK`.
- Decode outputs (`ctrl_field`, register addresses, immediates) are valid one cycle after the `IRWrite` edge and stable until the next `IRWrite`.
- Branch: target computed in cycle N lands in ALUOut at edge N. In cycle N+1 (`Branch`, `PCWrite`, `PCSrc` = 1), `cond` is evaluated from the live flags; PC = target at edge N+1 if taken, otherwise PC is unchanged.
- `Reset` asserted mid-instruction: all state returns to reset values immediately, independent of `CLK`. First edge after deassertion with `IRWrite` fetches from `RESET_PC`.
- `cycle_cnt` increments every non-reset edge and wraps at 16 bits.

## Test plan
- **Reset + fetch:**
  - Stimulus: `Reset` pulse; `mem_rdata` = 16'h1402, `IRWrite` = `PCWrite` = 1, `alu_result` = 2.
  - Required: after the edge, `pc_q` = 2, `ir_q` = 16'h1402, `ctrl_field` = 7'h02, `retired_cnt` = 1.
- **Decode fields:**
  - Stimulus: IR = 16'hFD81.
  - Required: `rs2` = 7, `rs1` = 7, `rd` = 3, `ctrl_field` = 7'h01, `imm6_sext` = 16'hFFFF, `imm9_sext` = 16'hFFFB.
- **Taken beq:**
  - Stimulus: cycle N `alu_result` = 16'h0040; cycle N+1 `Branch` = `PCWrite` = `PCSrc` = 1, `BranchType` = 00, `alu_zero` = 1.
  - Required: `pc_q` = 16'h0040, `branch_taken` = 1.
- **Not-taken bge:**
  - Stimulus: same sequence with `BranchType` = 11, `alu_neg` = 1.
  - Required: `pc_q` unchanged, `branch_taken` = 0.
- **Load/store addressing:**
  - Stimulus: `alu_out_q` = 16'h0100, `IoD` = 1, `MemR` = 1, `mem_rdata` = 16'hBEEF.
  - Required: `mem_addr` = 16'h0100, `mdr_q` = 16'hBEEF next cycle. With `MemW` = 1, `mem_wdata` = `b_data`.
- **Async reset mid-branch + misalign:**
  - Stimulus: PC written with 16'h0003, then `Reset` asserted between edges.
  - Required: `misalign` = 1 before reset; immediately after reset `pc_q` = `RESET_PC` and `misalign` = 0.
